// File: rtl/ariscv_aclk_monitor_pkg.sv
// Shared constants for the asynchronous-pipeline clock monitor: stage indices
// of the control path and default sizing.
package ariscv_mon_pkg;

  localparam int STG_PC_FD  = 0;
  localparam int STG_FD_DE  = 1;
  localparam int STG_DE_EM  = 2;
  localparam int STG_EM_MW  = 3;
  localparam int STG_EM_PC  = 4;
  localparam int STG_MW_REG = 5;

  localparam int N_STAGES_DEF    = 6;
  localparam int CNT_W_DEF       = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 1024;

  // A single-stage monitor still needs a 1-bit select port.
  function automatic int sel_width(input int n_stages);
    return (n_stages > 1) ? $clog2(n_stages) : 1;
  endfunction

  // Arm counter must be able to hold SYNC_STAGES+1.
  function automatic int arm_width(input int sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/ariscv_aclk_monitor_if.sv
// Monitor-side bundle: sampled stage clocks and controls in, debug
// observation (counts, edge pulses, stall/arming status) out.
interface ariscv_aclk_monitor_if
  import ariscv_mon_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SEL_W    = sel_width(N_STAGES)
);

  logic [N_STAGES-1:0] i_aclk;
  logic                i_en;
  logic                i_clr;
  logic [SEL_W-1:0]    i_sel;
  logic [CNT_W-1:0]    o_cnt;
  logic [N_STAGES-1:0] o_edge;
  logic                o_stall;
  logic                o_armed;

  modport master (
    output i_aclk, i_en, i_clr, i_sel,
    input  o_cnt, o_edge, o_stall, o_armed
  );

  modport slave (
    input  i_aclk, i_en, i_clr, i_sel,
    output o_cnt, o_edge, o_stall, o_armed
  );

endinterface

// File: rtl/ariscv_aclk_monitor_sync.sv
// Single-bit synchronizer for one local stage clock, with a previous-value
// flop so a rising edge shows up as a one-cycle level in the clk domain.
module ariscv_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_sync,
  input  logic aclk,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain; prev_r lags the synchronized value by one cycle.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], aclk};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/ariscv_aclk_monitor.sv
// Observer for the self-timed pipeline: counts rising edges of each local
// stage clock in the clk domain and flags a stall when nothing fires.
module ariscv_aclk_monitor
  import ariscv_mon_pkg::*;
#(
  parameter int N_STAGES    = N_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int TO_W        = $clog2(TIMEOUT + 1),
  parameter int SEL_W       = sel_width(N_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  ariscv_aclk_monitor_if.slave  mon
);

  localparam int                ARM_W    = arm_width(SYNC_STAGES);
  localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [N_STAGES-1:0] rise_s;
  logic [N_STAGES-1:0] edge_r;
  logic [N_STAGES-1:0] o_edge_r;
  logic [ARM_W-1:0]    arm_r;
  logic                armed_r;
  logic [CNT_W-1:0]    cnt_r [N_STAGES];
  logic [TO_W-1:0]     to_r;
  logic                stall_r;
  logic [SEL_W-1:0]    sel_s;
  logic [CNT_W-1:0]    rd_s;
  logic [CNT_W-1:0]    cnt_rd_r;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_sync
    ariscv_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
      .clk      (clk),
      .rst_sync (rst_sync),
      .aclk     (mon.i_aclk[g]),
      .rise     (rise_s[g])
    );
  end

  // Arming: a stage clock held high through reset reaches the end of the
  // synchronizer as a fake rising edge; it is dropped while still unarmed.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      arm_r   <= '0;
      armed_r <= 1'b0;
    end else begin
      if (!armed_r) begin
        arm_r <= arm_r + 1'b1;
      end else begin
        arm_r <= arm_r;
      end
      armed_r <= armed_r | (arm_r == ARM_LAST);
    end
  end

  // Edge capture stage; o_edge follows edges regardless of i_en or i_clr.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      edge_r   <= '0;
      o_edge_r <= '0;
    end else begin
      edge_r   <= armed_r ? rise_s : '0;
      o_edge_r <= edge_r;
    end
  end

  // Per-stage saturating counters, idle timeout and sticky stall flag.
  // i_clr outranks a coincident edge so a clear always leaves zero.
  always_ff @(posedge clk) begin
    if (rst_sync || mon.i_clr) begin
      for (int i = 0; i < N_STAGES; i++) begin
        cnt_r[i] <= '0;
      end
      to_r    <= '0;
      stall_r <= 1'b0;
    end else begin
      if (armed_r && mon.i_en) begin
        for (int i = 0; i < N_STAGES; i++) begin
          if (edge_r[i] && (cnt_r[i] != CNT_MAX)) begin
            cnt_r[i] <= cnt_r[i] + 1'b1;
          end
        end
        if (|edge_r) begin
          to_r <= '0;
        end else if (to_r != TO_MAX) begin
          to_r <= to_r + 1'b1;
        end
      end
      if (to_r == TO_MAX) begin
        stall_r <= 1'b1;
      end
    end
  end

  assign sel_s = mon.i_sel;

  // Read mux; selects beyond the last stage read as zero.
  always_comb begin
    rd_s = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (sel_s == SEL_W'(i)) begin
        rd_s = cnt_r[i];
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt_rd_r <= '0;
    end else begin
      cnt_rd_r <= rd_s;
    end
  end

  assign mon.o_cnt   = cnt_rd_r;
  assign mon.o_edge  = o_edge_r;
  assign mon.o_stall = stall_r;
  assign mon.o_armed = armed_r;

endmodule
